addr_data_fifo: RTL
===================

// Module: addr_data_fifo
// PURPOSE
//  Parametrised synchronous FIFO storing {address, data} pairs. Buffers memory
//  requests between the core-side request port and the memory/cache interface.
//  Supersedes the single-entry address FIFOs with the following additions:
//  - arbitrary depth
//  - true simultaneous push/pop
//  - occupancy count and almost-full flag
//  - sticky error flags
//  - flush
//  - optional first-word-fall-through read mode
// PARAMETERS
//  DEPTH          4    entries; >=2, any integer (non-power-of-2 allowed)
//  ADDRESS_WIDTH  32   address field width
//  DATA_WIDTH     128  data field width
//  AF_THRESH      3    almost_full asserts when count >= AF_THRESH; 1..DEPTH
// PORTS
//  clk          in   1                    single clock, rising edge
//  rst_n        in   1                    asynchronous, active-low reset
//  flush        in   1                    synchronous clear of contents/flags
//  wr_en        in   1                    push request
//  address_in   in   ADDRESS_WIDTH        push address
//  data_in      in   DATA_WIDTH           push data
//  rd_en        in   1                    pop request
//  address_out  out  ADDRESS_WIDTH        popped/head address
//  data_out     out  DATA_WIDTH           popped/head data
//  rd_valid     out  1                    address_out/data_out valid
//  full         out  1                    count == DEPTH
//  empty        out  1                    count == 0
//  almost_full  out  1                    count >= AF_THRESH
//  count        out  $clog2(DEPTH+1)      current occupancy
//  overflow     out  1                    sticky: wr_en seen while full
//  underflow    out  1                    sticky: rd_en seen while empty
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers=0, count=0, rd_valid=0, outputs=0,
//    overflow=underflow=0. Status: empty=1, full=0, almost_full=0.
//    Storage array is not reset.
//  - full/empty/almost_full: combinational from registered count; no lag.
//  - Push accepted iff wr_en && !full. Pop accepted iff rd_en && !empty.
//  - Push and pop in same cycle: both accepted if allowed; count unchanged.
//    When full, wr_en+rd_en pops only (no bypass). When empty, wr_en+rd_en
//    pushes only.
//  - Pointer wrap: pointer at DEPTH-1 wraps to 0; ptr width max(1,$clog2(DEPTH)).
//  - count: +1 push-only, -1 pop-only, held otherwise; never exceeds DEPTH.
//  - Rejected requests: rejected push leaves the FIFO unchanged and sets
//    overflow; rejected pop sets underflow. Flags stay set until flush or reset.
//  - flush (sync, highest priority): pointers, count, overflow, underflow,
//    rd_valid -> 0. Concurrent wr_en/rd_en are ignored that cycle.
//    address_out/data_out -> 0.
//  - Illegal DEPTH/AF_THRESH: $error at elaboration.
// CONFIGURATION
//  FIFO_FWFT_EN undefined (default, registered read):
//    - Accepted pop at edge N: entry appears on address_out/data_out after
//      edge N, with rd_valid=1 for exactly one cycle.
//    - Latency is 1 cycle. Outputs hold the last popped value while
//      rd_valid=0.
//  FIFO_FWFT_EN defined (first-word-fall-through):
//    - address_out/data_out show the head entry combinationally.
//    - rd_valid = !empty. Outputs are 0 when empty.
//    - rd_en acknowledges/pops the shown entry. Latency is 0 cycles.
//    - A pushed entry is visible the cycle after the push edge.
// TESTING (DEPTH=4, AF_THRESH=3, ADDRESS_WIDTH=32, DATA_WIDTH=32)
//  1. Push A0..A3 (addr=0x10+i, data=0xD0+i), then 4 pops.
//     -> full=1 after 4th push; almost_full=1 at count=3.
//     -> Pops return in order 0x10/0xD0..0x13/0xD3; empty=1 at end; count=0.
//  2. Wrap: push 3, pop 2, push 3.
//     -> count=4, full=1; next 4 pops return entries in order across the wrap.
//  3. Simultaneous: count=2, wr_en+rd_en for 5 cycles.
//     -> count stays 2; output order preserved.
//     -> Full + both: pop only, count 4->3.
//     -> Empty + both: push only, count 0->1.
//  4. Errors: wr_en when full -> overflow=1, contents unchanged.
//     rd_en when empty -> underflow=1. Both flags hold until flush.
//  5. Flush with wr_en=rd_en=1 at count=3.
//     -> Next cycle count=0, empty=1, flags=0, rd_valid=0; push ignored.
//  6. Async reset mid-stream (rst_n low between edges).
//     -> Outputs/flags at reset values immediately, not at the next edge.
//     Run 1-6 with and without FIFO_FWFT_EN; check latency per CONFIGURATION.

Source files
------------

// File: rtl/addr_data_fifo.sv
// Synchronous {address, data} FIFO between the core request port and the memory/cache side; optional FWFT read via FIFO_FWFT_EN.
// Latency: registered read shows a popped entry one cycle after the pop edge; FWFT shows the head combinationally (0 cycles).
// Backpressure: push refused when full (sets sticky overflow), pop refused when empty (sets sticky underflow); flush clears all.
module addr_data_fifo #(
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int AF_THRESH     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [ADDRESS_WIDTH-1:0]     address_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         rd_en,
    output logic [ADDRESS_WIDTH-1:0]     address_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
        $error("addr_data_fifo: illegal DEPTH/AF_THRESH combination");
    end

    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [DEPTH];

    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push, pop;

    // Non-power-of-2 depths need an explicit wrap rather than natural rollover.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_W'(AF_THRESH));
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

    always_comb begin
        push     = wr_en && !full && !flush;
        pop      = rd_en && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            if (pop && !push) count_d = count_q - CNT_W'(1);
            if (wr_en && full)  ovf_d = 1'b1;
            if (rd_en && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= address_in;
            data_mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_valid    = !empty;
    assign address_out = empty ? '0 : addr_mem[rd_ptr_q];
    assign data_out    = empty ? '0 : data_mem[rd_ptr_q];
`else
    logic [ADDRESS_WIDTH-1:0] addr_out_q, addr_out_d;
    logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
    logic                     rd_valid_q, rd_valid_d;

    // Output registers hold the last popped entry until the next pop or flush.
    always_comb begin
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;
        rd_valid_d = pop;
        if (flush) begin
            addr_out_d = '0;
            data_out_d = '0;
        end else if (pop) begin
            addr_out_d = addr_mem[rd_ptr_q];
            data_out_d = data_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out_q <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign address_out = addr_out_q;
    assign data_out    = data_out_q;
`endif

endmodule
